// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared types and constants for the 2-byte command link wrapper.
// Optional inter-byte timeout is enabled by defining UART_WRAP_TIMEOUT_EN.
package uart_cmd_pkg;

    typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} rx_state_t;

    localparam int unsigned TIMEOUT_CYC_DFLT = 1_000_000;
    localparam int          CMD_W            = 16;
    localparam int          RESP_W           = 8;
    // 50 MHz / 115200 baud
    localparam int          BAUD_DIV_DFLT    = 434;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Command/response handshake bundle between the link wrapper and the command processor.
// master = link wrapper side, slave = command processor side.
interface uart_cmd_wrapper_if;
    import uart_cmd_pkg::*;

    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic              cmd_ovr;
    logic [RESP_W-1:0] resp;
    logic              send_resp;
    logic              resp_busy;
    logic              resp_sent;
    logic              frm_err;

    modport master (
        output cmd, cmd_rdy, cmd_ovr, resp_busy, resp_sent, frm_err,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, cmd_ovr, resp_busy, resp_sent, frm_err,
        output clr_cmd_rdy, resp, send_resp
    );

endinterface

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART transceiver; rx_rdy rises mid stop bit and holds until clr_rx_rdy, tx_done holds until next trmt.
// Latency: one bit period per serial bit; no backpressure, trmt while transmitting is ignored.
module uart_cmd_wrapper_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);
    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);

    logic          tx_busy;
    logic [9:0]    tx_sh;
    logic [3:0]    tx_bits;
    logic [BW-1:0] tx_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bits <= '0;
            tx_cnt  <= '0;
            tx_done <= 1'b0;
        end else if (trmt && !tx_busy) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_bits <= '0;
            tx_cnt  <= FULL;
            tx_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_cnt == '0) begin
                tx_cnt <= FULL;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - BW'(1);
            end
        end
    end

    // Shift register back-fills with ones, so the line idles high.
    assign TX = tx_sh[0];

    logic          rx_meta, rx_s;
    logic          rx_busy;
    logic [3:0]    rx_bits;
    logic [BW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_busy <= 1'b0;
            rx_bits <= '0;
            rx_cnt  <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF;
                    rx_bits <= '0;
                end
            end else if (rx_cnt == '0) begin
                rx_cnt  <= FULL;
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                end else if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s) begin
                        rx_data <= rx_sh;
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    rx_sh <= {rx_s, rx_sh[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt - BW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Remote command receiver: two RX bytes -> 16-bit cmd (cmd_rdy one clk after low byte), one-byte response on TX.
// No backpressure: unacked cmd is overwritten (cmd_ovr), send_resp dropped while resp_busy; timeout via UART_WRAP_TIMEOUT_EN.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
    parameter int          CNT_W       = $clog2(TIMEOUT_CYC + 1),
    parameter int          BAUD_DIV    = BAUD_DIV_DFLT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RX,
    output logic          TX,
    uart_cmd_wrapper_if.master cif
);
    logic              rx_rdy, clr_rx_rdy, trmt, tx_done;
    logic [7:0]        rx_data;
    logic [RESP_W-1:0] tx_data;

    uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_data    (rx_data),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    rx_state_t state, state_nxt;
    logic      ld_hi, ld_cmd, tmo, tmo_evt;

`ifdef UART_WRAP_TIMEOUT_EN
    logic [CNT_W-1:0] tmr;

    assign tmo = (state == WAIT_LO) && (tmr == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          tmr <= '0;
        else if (ld_hi)                      tmr <= '0;
        else if (state == WAIT_LO && !tmo)   tmr <= tmr + CNT_W'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HI;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HI: if (rx_rdy) state_nxt = WAIT_LO;
            WAIT_LO: if (rx_rdy || tmo) state_nxt = WAIT_HI;
            default: state_nxt = WAIT_HI;
        endcase
    end

    // A byte landing in the expiry cycle still counts as the low byte.
    always_comb begin
        clr_rx_rdy = rx_rdy;
        ld_hi      = 1'b0;
        ld_cmd     = 1'b0;
        tmo_evt    = 1'b0;
        case (state)
            WAIT_HI: ld_hi = rx_rdy;
            WAIT_LO: begin
                ld_cmd  = rx_rdy;
                tmo_evt = tmo && !rx_rdy;
            end
            default: ;
        endcase
    end

    logic [7:0]       hi_reg;
    logic [CMD_W-1:0] cmd_q;
    logic             cmd_rdy_q, cmd_ovr_q, frm_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg    <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            cmd_ovr_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (ld_hi)        hi_reg <= rx_data;
            else if (tmo_evt) hi_reg <= '0;
            if (ld_cmd) cmd_q <= {hi_reg, rx_data};
            if (ld_cmd)                cmd_rdy_q <= 1'b1;
            else if (cif.clr_cmd_rdy)  cmd_rdy_q <= 1'b0;
            cmd_ovr_q <= ld_cmd && cmd_rdy_q && !cif.clr_cmd_rdy;
            frm_err_q <= tmo_evt;
        end
    end

    logic resp_busy_q, resp_sent_q, tx_done_q;
    logic tx_done_rise;

    assign tx_done_rise = tx_done && !tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= '0;
            trmt        <= 1'b0;
            resp_busy_q <= 1'b0;
            resp_sent_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            resp_sent_q <= tx_done_rise;
            trmt        <= cif.send_resp && !resp_busy_q;
            if (cif.send_resp && !resp_busy_q) begin
                tx_data     <= cif.resp;
                resp_busy_q <= 1'b1;
            end else if (tx_done_rise) begin
                resp_busy_q <= 1'b0;
            end
        end
    end

    assign cif.cmd       = cmd_q;
    assign cif.cmd_rdy   = cmd_rdy_q;
    assign cif.cmd_ovr   = cmd_ovr_q;
    assign cif.frm_err   = frm_err_q;
    assign cif.resp_busy = resp_busy_q;
    assign cif.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: serial byte driver on RX, bit sampler on TX.
module tb_uart_cmd_wrapper;
    localparam int BAUD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic RX, TX;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ovr_cnt  = 0;
    int   sent_cnt = 0;
    int   ferr_cnt = 0;
    bit   seen_5566 = 1'b0;

    uart_cmd_wrapper_if cif();

    uart_cmd_wrapper #(.TIMEOUT_CYC(100), .BAUD_DIV(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .cif   (cif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cif.cmd_ovr === 1'b1)   ovr_cnt++;
        if (cif.resp_sent === 1'b1) sent_cnt++;
        if (cif.frm_err === 1'b1)   ferr_cnt++;
        if (cif.cmd_rdy === 1'b1 && cif.cmd === 16'h5566) seen_5566 = 1'b1;
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = f[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cif.cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_cmd();
        @(negedge clk); cif.clr_cmd_rdy = 1'b1;
        @(negedge clk); cif.clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (cif.cmd !== 16'h0000) $display("FAIL reset_cmd got %h exp 0000", cif.cmd); else n_pass++;
        n_checks++; if (cif.cmd_rdy !== 1'b0) $display("FAIL reset_cmd_rdy got %b exp 0", cif.cmd_rdy); else n_pass++;
        n_checks++; if (cif.cmd_ovr !== 1'b0) $display("FAIL reset_cmd_ovr got %b exp 0", cif.cmd_ovr); else n_pass++;
        n_checks++; if (cif.resp_busy !== 1'b0) $display("FAIL reset_resp_busy got %b exp 0", cif.resp_busy); else n_pass++;
        n_checks++; if (cif.resp_sent !== 1'b0) $display("FAIL reset_resp_sent got %b exp 0", cif.resp_sent); else n_pass++;
        n_checks++; if (cif.frm_err !== 1'b0) $display("FAIL reset_frm_err got %b exp 0", cif.frm_err); else n_pass++;
        n_checks++; if (TX !== 1'b1) $display("FAIL reset_tx_idle got %b exp 1", TX); else n_pass++;
    endtask

    task automatic test_basic_cmd();
        bit ok;
        send_byte(8'hA5);
        repeat (4) @(negedge clk);
        n_checks++; if (cif.cmd_rdy !== 1'b0) $display("FAIL basic_no_rdy_after_hi got %b exp 0", cif.cmd_rdy); else n_pass++;
        send_byte(8'h3C);
        wait_rdy(ok);
        n_checks++; if (!ok) $display("FAIL basic_rdy_timeout got 0 exp 1"); else n_pass++;
        n_checks++; if (cif.cmd !== 16'hA53C) $display("FAIL basic_cmd got %h exp a53c", cif.cmd); else n_pass++;
        ack_cmd();
        n_checks++; if (cif.cmd_rdy !== 1'b0) $display("FAIL basic_clr got %b exp 0", cif.cmd_rdy); else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        int base;
        base = ovr_cnt;
        send_byte(8'h12); send_byte(8'h34);
        wait_rdy(ok);
        n_checks++; if (!ok || cif.cmd !== 16'h1234) $display("FAIL ovr_first got %h rdy %b exp 1234 rdy 1", cif.cmd, ok); else n_pass++;
        send_byte(8'hBE);
        repeat (4) @(negedge clk);
        n_checks++; if (cif.cmd_rdy !== 1'b1 || cif.cmd !== 16'h1234) $display("FAIL ovr_hold_after_hi got %h rdy %b exp 1234 rdy 1", cif.cmd, cif.cmd_rdy); else n_pass++;
        send_byte(8'hEF);
        repeat (4) @(negedge clk);
        n_checks++; if (cif.cmd !== 16'hBEEF) $display("FAIL ovr_cmd got %h exp beef", cif.cmd); else n_pass++;
        n_checks++; if (cif.cmd_rdy !== 1'b1) $display("FAIL ovr_rdy got %b exp 1", cif.cmd_rdy); else n_pass++;
        n_checks++; if (ovr_cnt - base !== 1) $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - base); else n_pass++;
        ack_cmd();
    endtask

    task automatic test_set_wins();
        bit seen;
        seen = 1'b0;
        @(negedge clk); cif.clr_cmd_rdy = 1'b1;
        fork
            begin send_byte(8'h5A); send_byte(8'hC3); end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (cif.cmd_rdy === 1'b1) begin
                        cif.clr_cmd_rdy = 1'b0;
                        seen = 1'b1;
                        break;
                    end
                end
                cif.clr_cmd_rdy = 1'b0;
            end
        join
        n_checks++; if (!seen) $display("FAIL setwins_rdy got 0 exp 1"); else n_pass++;
        n_checks++; if (cif.cmd !== 16'h5AC3) $display("FAIL setwins_cmd got %h exp 5ac3", cif.cmd); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (cif.cmd_rdy !== 1'b1) $display("FAIL setwins_hold got %b exp 1", cif.cmd_rdy); else n_pass++;
        ack_cmd();
    endtask

    task automatic test_resp();
        int         base;
        bit         got, drop, quiet;
        logic [7:0] data;
        base = sent_cnt;
        got = 1'b0; drop = 1'b0; quiet = 1'b1; data = 8'h00;
        @(negedge clk); cif.resp = 8'h0A; cif.send_resp = 1'b1;
        @(negedge clk); cif.send_resp = 1'b0; cif.resp = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (TX === 1'b0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!got) $display("FAIL resp_start got 0 exp 1"); else n_pass++;
        n_checks++; if (cif.resp_busy !== 1'b1) $display("FAIL resp_busy_set got %b exp 1", cif.resp_busy); else n_pass++;
        repeat (BAUD / 2) @(negedge clk);
        n_checks++; if (TX !== 1'b0) $display("FAIL resp_start_mid got %b exp 0", TX); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (i == 3 && c == 0) begin cif.resp = 8'hFF; cif.send_resp = 1'b1; end
                if (i == 3 && c == 1) begin cif.send_resp = 1'b0; cif.resp = 8'h00; end
                if (cif.resp_busy !== 1'b1) drop = 1'b1;
            end
            data[i] = TX;
        end
        n_checks++; if (data !== 8'h0A) $display("FAIL resp_data got %h exp 0a", data); else n_pass++;
        n_checks++; if (drop) $display("FAIL resp_busy_frame got 0 exp 1"); else n_pass++;
        repeat (BAUD) @(negedge clk);
        n_checks++; if (TX !== 1'b1) $display("FAIL resp_stop got %b exp 1", TX); else n_pass++;
        repeat (BAUD) @(negedge clk);
        n_checks++; if (cif.resp_busy !== 1'b0) $display("FAIL resp_busy_clr got %b exp 0", cif.resp_busy); else n_pass++;
        for (int i = 0; i < 3 * BAUD; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cif.resp_busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (!quiet) $display("FAIL resp_dropped_2nd got frame exp idle"); else n_pass++;
        n_checks++; if (sent_cnt - base !== 1) $display("FAIL resp_sent_pulses got %0d exp 1", sent_cnt - base); else n_pass++;
    endtask

    task automatic test_timeout();
        int base, at;
        bit ok;
        base = ferr_cnt;
        at = -1;
        send_byte(8'h55);
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (at < 0 && cif.frm_err === 1'b1) at = i;
        end
`ifdef UART_WRAP_TIMEOUT_EN
        n_checks++; if (at < 90 || at > 104) $display("FAIL tmo_when got %0d exp 90..104", at); else n_pass++;
        n_checks++; if (ferr_cnt - base !== 1) $display("FAIL tmo_pulses got %0d exp 1", ferr_cnt - base); else n_pass++;
        send_byte(8'h66); send_byte(8'h77);
        wait_rdy(ok);
        n_checks++; if (!ok || cif.cmd !== 16'h6677) $display("FAIL tmo_cmd got %h rdy %b exp 6677 rdy 1", cif.cmd, ok); else n_pass++;
        n_checks++; if (seen_5566) $display("FAIL tmo_stale got 5566 exp none"); else n_pass++;
`else
        n_checks++; if (ferr_cnt - base !== 0) $display("FAIL notmo_frm_err got %0d exp 0 (first at %0d)", ferr_cnt - base, at); else n_pass++;
        send_byte(8'h66);
        wait_rdy(ok);
        n_checks++; if (!ok || cif.cmd !== 16'h5566) $display("FAIL notmo_cmd got %h rdy %b exp 5566 rdy 1", cif.cmd, ok); else n_pass++;
`endif
        ack_cmd();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_byte(8'hC0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (cif.cmd !== 16'h0000 || cif.cmd_rdy !== 1'b0 || cif.cmd_ovr !== 1'b0)
            $display("FAIL rstmid_cmd got %h rdy %b ovr %b exp 0000 0 0", cif.cmd, cif.cmd_rdy, cif.cmd_ovr); else n_pass++;
        n_checks++; if (cif.resp_busy !== 1'b0 || cif.resp_sent !== 1'b0 || cif.frm_err !== 1'b0 || TX !== 1'b1)
            $display("FAIL rstmid_misc got busy %b sent %b ferr %b tx %b exp 0 0 0 1", cif.resp_busy, cif.resp_sent, cif.frm_err, TX); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h01);
        repeat (4) @(negedge clk);
        n_checks++; if (cif.cmd_rdy !== 1'b0) $display("FAIL rstmid_partial got rdy %b cmd %h exp 0", cif.cmd_rdy, cif.cmd); else n_pass++;
        send_byte(8'h02);
        wait_rdy(ok);
        n_checks++; if (!ok || cif.cmd !== 16'h0102) $display("FAIL rstmid_cmd_after got %h rdy %b exp 0102 rdy 1", cif.cmd, ok); else n_pass++;
        ack_cmd();
    endtask

    initial begin
        rst_n = 1'b0;
        RX = 1'b1;
        cif.clr_cmd_rdy = 1'b0;
        cif.send_resp   = 1'b0;
        cif.resp        = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_basic_cmd();
        test_overrun();
        test_set_wins();
        test_resp();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got hang exp finish");
        $fatal(1, "bench timeout");
    end

endmodule
